// File: rtl/yacc_pkg.sv
// Shared constants, FSM states and per-way metadata layout for the YACC tag controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package yacc_pkg;

    localparam int TAG_W   = 21;
    localparam int SETS    = 8;
    localparam int WAYS    = 4;
    localparam int SUBBLK  = 4;
    localparam int LFU_W   = 4;
    localparam int STAT_W  = 16;

    localparam int IDX_W   = $clog2(SETS);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int SB_W    = $clog2(SUBBLK);

    localparam int TAG_LSB = 11;
    localparam int IDX_LSB = 8;
    localparam int SB_LSB  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL_REQ,
        ST_UPDATE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SUBBLK-1:0] valid_mask;
        logic [LFU_W-1:0]  lfu;
        logic [WAY_W-1:0]  lru_age;
    } way_meta_t;

    function automatic logic [LFU_W-1:0] lfu_inc(input logic [LFU_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/yacc_victim_sel.sv
// Combinational victim choice for one set: empty way first, else min LFU, then oldest, then lowest index.
// Zero latency, no flow control.
module yacc_victim_sel
    import yacc_pkg::*;
(
    input  way_meta_t [WAYS-1:0] meta,
    output logic [WAY_W-1:0]     victim_way,
    output logic                 victim_valid
);

    logic             found_empty;
    logic [WAY_W-1:0] empty_way;
    logic [WAY_W-1:0] best_way;

    always_comb begin
        found_empty = 1'b0;
        empty_way   = '0;
        // Descending scan so the lowest empty index is the one that sticks.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (meta[w].valid_mask == '0) begin
                found_empty = 1'b1;
                empty_way   = WAY_W'(w);
            end
        end

        // Strict comparisons keep the lower index on a complete tie.
        best_way = '0;
        for (int w = 1; w < WAYS; w++) begin
            if ((meta[w].lfu < meta[best_way].lfu) ||
                ((meta[w].lfu == meta[best_way].lfu) &&
                 (meta[w].lru_age > meta[best_way].lru_age))) begin
                best_way = WAY_W'(w);
            end
        end

        victim_way   = found_empty ? empty_way : best_way;
        victim_valid = !found_empty;
    end

endmodule

// File: rtl/yacc_replacement_ctrl.sv
// Tag/metadata sequencer for the compressed YACC cache: hit in 2 cycles, miss 2 cycles after fill_ack.
// One access at a time; req_ready only in IDLE, fill request held until fill_ack, no response backpressure.
module yacc_replacement_ctrl
    import yacc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic              resp_evict,
    output logic              fill_req_valid,
    output logic [31:0]       fill_req_addr,
    input  logic              fill_ack,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
);

    localparam logic [31:0] FILL_MASK = ~32'h0000_003f;

    state_t state_q, state_d;

    logic [31:0]          addr_q;
    logic                 sbmiss_q;
    way_meta_t [WAYS-1:0] meta_q [SETS];

    logic [TAG_W-1:0]     acc_tag;
    logic [IDX_W-1:0]     acc_idx;
    logic [SB_W-1:0]      acc_sb;
    logic [SUBBLK-1:0]    sb_onehot;

    way_meta_t [WAYS-1:0] set_meta;
    way_meta_t [WAYS-1:0] set_new;

    logic                 match_any;
    logic [WAY_W-1:0]     match_way;
    logic                 lookup_hit;
    logic [WAY_W-1:0]     victim_way;
    logic                 victim_valid;
    logic [WAY_W-1:0]     acc_way;
    logic [WAY_W-1:0]     old_age;
    logic                 meta_wr;

    assign acc_tag       = addr_q[31:TAG_LSB];
    assign acc_idx       = addr_q[TAG_LSB-1:IDX_LSB];
    assign acc_sb        = addr_q[IDX_LSB-1:SB_LSB];
    assign sb_onehot     = SUBBLK'(1) << acc_sb;
    assign set_meta      = meta_q[acc_idx];
    assign fill_req_addr = addr_q & FILL_MASK;

    // A superblock with an empty mask holds no data, so its stale tag must not match.
    always_comb begin
        match_any = 1'b0;
        match_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if ((set_meta[w].valid_mask != '0) && (set_meta[w].tag == acc_tag)) begin
                match_any = 1'b1;
                match_way = WAY_W'(w);
            end
        end
        lookup_hit = match_any && set_meta[match_way].valid_mask[acc_sb];
    end

    yacc_victim_sel u_victim_sel (
        .meta         (set_meta),
        .victim_way   (victim_way),
        .victim_valid (victim_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        fill_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP:   state_d = lookup_hit ? ST_RESP : ST_FILL_REQ;
            ST_FILL_REQ: begin
                fill_req_valid = 1'b1;
                if (fill_ack) state_d = ST_UPDATE;
            end
            ST_UPDATE:   state_d = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // resp_way doubles as the target way carried from LOOKUP into UPDATE.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            sbmiss_q   <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            resp_evict <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) addr_q <= req_addr;
                ST_LOOKUP: begin
                    resp_hit <= lookup_hit;
                    sbmiss_q <= match_any;
                    if (lookup_hit) begin
                        resp_way   <= match_way;
                        resp_evict <= 1'b0;
                        hit_count  <= stat_inc(hit_count);
                    end else begin
                        resp_way   <= match_any ? match_way : victim_way;
                        resp_evict <= !match_any && victim_valid;
                        miss_count <= stat_inc(miss_count);
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_way = (state_q == ST_LOOKUP) ? match_way : resp_way;
    assign old_age = set_meta[acc_way].lru_age;
    assign meta_wr = ((state_q == ST_LOOKUP) && lookup_hit) || (state_q == ST_UPDATE);

    always_comb begin
        set_new = set_meta;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc_way)
                set_new[w].lru_age = '0;
            else if (set_meta[w].lru_age < old_age)
                set_new[w].lru_age = set_meta[w].lru_age + 1'b1;
        end
        if ((state_q == ST_UPDATE) && !sbmiss_q) begin
            set_new[acc_way].tag        = acc_tag;
            set_new[acc_way].valid_mask = sb_onehot;
            set_new[acc_way].lfu        = LFU_W'(1);
        end else begin
            set_new[acc_way].lfu = lfu_inc(set_meta[acc_way].lfu);
            if (state_q == ST_UPDATE)
                set_new[acc_way].valid_mask = set_meta[acc_way].valid_mask | sb_onehot;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    meta_q[s][w].tag        <= '0;
                    meta_q[s][w].valid_mask <= '0;
                    meta_q[s][w].lfu        <= '0;
                    meta_q[s][w].lru_age    <= WAY_W'(w);
                end
            end
        end else if (meta_wr) begin
            meta_q[acc_idx] <= set_new;
        end
    end

endmodule

// File: tb/tb_yacc_replacement_ctrl.sv
// Self-checking bench for yacc_replacement_ctrl: directed scenarios plus random traffic
// compared against a recency-list / count-based model of the cache metadata.
module tb_yacc_replacement_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        resp_evict;
    logic        fill_req_valid;
    logic [31:0] fill_req_addr;
    logic        fill_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks   = 0;
    int failures = 0;

    yacc_replacement_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_way       (resp_way),
        .resp_evict     (resp_evict),
        .fill_req_valid (fill_req_valid),
        .fill_req_addr  (fill_req_addr),
        .fill_ack       (fill_ack),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        hit;
        logic [1:0]  way;
        logic        evict;
        logic [7:0]  lat;
        logic [31:0] fill_addr;
        logic [15:0] hits;
        logic [15:0] misses;
    } res_t;

    // Reference model: tags/masks/counts per way, recency as a most-recent-first list.
    logic [20:0] m_tag  [8][4];
    logic [3:0]  m_mask [8][4];
    int          m_lfu  [8][4];
    int          m_rec  [8][4];
    int          m_hits;
    int          m_misses;

    task automatic model_reset();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++) begin
                m_tag[s][w]  = '0;
                m_mask[s][w] = '0;
                m_lfu[s][w]  = 0;
                m_rec[s][w]  = w;
            end
        m_hits   = 0;
        m_misses = 0;
    endtask

    function automatic int age_of(input int s, input int w);
        int a;
        a = 0;
        for (int p = 0; p < 4; p++) if (m_rec[s][p] == w) a = p;
        return a;
    endfunction

    task automatic touch(input int s, input int w);
        int p;
        p = age_of(s, w);
        for (int i = p; i > 0; i--) m_rec[s][i] = m_rec[s][i-1];
        m_rec[s][0] = w;
    endtask

    task automatic model_access(input logic [31:0] a, input int ack_k, output res_t e);
        logic [20:0] t;
        int s, sb, mw, way;
        t  = a[31:11];
        s  = int'(a[10:8]);
        sb = int'(a[7:6]);
        e  = '0;
        mw = -1;
        for (int w = 0; w < 4; w++)
            if (mw < 0 && m_mask[s][w] != 0 && m_tag[s][w] == t) mw = w;
        if (mw >= 0 && m_mask[s][mw][sb]) begin
            e.hit = 1'b1;
            way   = mw;
            if (m_lfu[s][way] < 15) m_lfu[s][way]++;
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_misses < 65535) m_misses++;
            e.fill_addr = {a[31:6], 6'b0};
            if (mw >= 0) begin
                way = mw;
                m_mask[s][way] = m_mask[s][way] | (4'b0001 << sb);
                if (m_lfu[s][way] < 15) m_lfu[s][way]++;
            end else begin
                way = -1;
                for (int w = 0; w < 4; w++) if (way < 0 && m_mask[s][w] == 0) way = w;
                if (way < 0) begin
                    way = 0;
                    for (int w = 1; w < 4; w++)
                        if (m_lfu[s][w] < m_lfu[s][way] ||
                            (m_lfu[s][w] == m_lfu[s][way] && age_of(s, w) > age_of(s, way)))
                            way = w;
                    e.evict = 1'b1;
                end
                m_tag[s][way]  = t;
                m_mask[s][way] = 4'b0001 << sb;
                m_lfu[s][way]  = 1;
            end
        end
        touch(s, way);
        e.way    = way[1:0];
        e.lat    = e.hit ? 8'd2 : 8'(ack_k + 2);
        e.hits   = 16'(m_hits);
        e.misses = 16'(m_misses);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        fill_ack  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Cycle 0 is the negedge where the request is driven; fill_ack is high during cycle ack_k.
    task automatic do_access(input logic [31:0] a, input int ack_k, input bit stray, output res_t g);
        int cyc;
        bit seen, done;
        g     = '0;
        g.lat = 8'hff;
        seen  = 1'b0;
        done  = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = $urandom;
        cyc       = 1;
        while (!done && cyc < 64) begin
            if (fill_req_valid) begin
                if (!seen) g.fill_addr = fill_req_addr;
                else if (fill_req_addr !== g.fill_addr) g.fill_addr = 32'hbad0_0bad;
                seen = 1'b1;
            end
            if (resp_valid) begin
                g.hit    = resp_hit;
                g.way    = resp_way;
                g.evict  = resp_evict;
                g.lat    = 8'(cyc);
                g.hits   = hit_count;
                g.misses = miss_count;
                done     = 1'b1;
            end
            fill_ack  = (cyc == ack_k) || (stray && cyc == 1);
            req_valid = stray && !done;
            @(negedge clock);
            cyc++;
        end
        fill_ack  = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL resp_pulse addr=%h resp_valid=%b req_ready=%b expected 0/1", a, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || fill_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake ready=%b resp_valid=%b fill_valid=%b expected 1/0/0",
                     req_ready, resp_valid, fill_req_valid);
        end
        checks++;
        if (resp_hit !== 1'b0 || resp_way !== 2'd0 || resp_evict !== 1'b0 || fill_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp hit=%b way=%0d evict=%b fill_addr=%h expected all zero",
                     resp_hit, resp_way, resp_evict, fill_req_addr);
        end
        checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_stats hits=%0d misses=%0d expected 0/0", hit_count, miss_count);
        end
    endtask

    task automatic test_cold_miss();
        res_t e, g;
        model_access(32'h0000_0040, 4, e);
        do_access(32'h0000_0040, 4, 1'b0, g);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL cold_miss got=%h exp=%h", g, e);
        end
        checks++;
        if (g.lat !== 8'd6 || g.fill_addr !== 32'h40 || g.hit !== 1'b0 || g.way !== 2'd0 ||
            g.evict !== 1'b0 || g.misses !== 16'd1) begin
            failures++;
            $display("FAIL cold_miss_fixed lat=%0d fill=%h hit=%b way=%0d evict=%b misses=%0d expected 6/40/0/0/0/1",
                     g.lat, g.fill_addr, g.hit, g.way, g.evict, g.misses);
        end
    endtask

    task automatic test_repeat_hit();
        res_t e, g;
        model_access(32'h0000_0040, 3, e);
        do_access(32'h0000_0040, 3, 1'b1, g);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL repeat_hit got=%h exp=%h", g, e);
        end
        checks++;
        if (g.lat !== 8'd2 || g.hit !== 1'b1 || g.way !== 2'd0 || g.hits !== 16'd1) begin
            failures++;
            $display("FAIL repeat_hit_fixed lat=%0d hit=%b way=%0d hits=%0d expected 2/1/0/1",
                     g.lat, g.hit, g.way, g.hits);
        end
    endtask

    task automatic test_subblock_miss();
        logic [31:0] seq [4];
        res_t e, g;
        seq[0] = 32'h0000_00c0;
        seq[1] = 32'h0000_0040;
        seq[2] = 32'h0000_00c0;
        seq[3] = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            model_access(seq[i], 3, e);
            do_access(seq[i], 3, 1'b0, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL subblock_%0d got=%h exp=%h", i, g, e);
            end
            if (i == 0) begin
                checks++;
                if (g.hit !== 1'b0 || g.way !== 2'd0 || g.evict !== 1'b0 || g.fill_addr !== 32'hc0) begin
                    failures++;
                    $display("FAIL subblock_fixed hit=%b way=%0d evict=%b fill=%h expected 0/0/0/c0",
                             g.hit, g.way, g.evict, g.fill_addr);
                end
            end
        end
    endtask

    task automatic run_seq(input string name, input logic [31:0] base, input logic [2:0] tags [9], input int n,
                           output res_t last);
        res_t e, g;
        logic [31:0] a;
        last = '0;
        for (int i = 0; i < n; i++) begin
            a = base | (32'(tags[i]) << 11);
            model_access(a, 2, e);
            do_access(a, 2, 1'b0, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s_%0d got=%h exp=%h", name, i, g, e);
            end
            last = g;
        end
    endtask

    task automatic test_lfu_victim();
        logic [2:0] tags [9];
        res_t last;
        apply_reset();
        tags = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
        run_seq("lfu_victim", 32'h0000_0040, tags, 9, last);
        checks++;
        if (last.way !== 2'd3 || last.evict !== 1'b1 || last.hit !== 1'b0) begin
            failures++;
            $display("FAIL lfu_victim_fixed way=%0d evict=%b hit=%b expected 3/1/0", last.way, last.evict, last.hit);
        end
    endtask

    task automatic test_lru_tiebreak();
        logic [2:0] tags [9];
        res_t last;
        apply_reset();
        tags = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
        run_seq("lru_tiebreak", 32'h0000_0100, tags, 5, last);
        checks++;
        if (last.way !== 2'd0 || last.evict !== 1'b1) begin
            failures++;
            $display("FAIL lru_tiebreak_fixed way=%0d evict=%b expected 0/1", last.way, last.evict);
        end
    endtask

    task automatic test_random();
        res_t e, g;
        logic [31:0] a;
        int k;
        bit stray;
        for (int i = 0; i < 250; i++) begin
            a = (32'($urandom_range(0, 5)) << 11) | (32'($urandom_range(0, 1)) << 8) |
                (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
            k     = 2 + int'($urandom_range(0, 3));
            stray = 1'($urandom_range(0, 1));
            model_access(a, k, e);
            do_access(a, k, stray, g);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL random_%0d addr=%h got=%h exp=%h", i, a, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        res_t e, g;
        bit seen;
        logic [31:0] a;
        a = 32'h1234_5680;
        apply_reset();
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clock);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            seen = fill_req_valid;
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL midfill_req fill_req_valid never rose, expected 1");
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (fill_req_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midfill_drop fill_valid=%b ready=%b expected 0/1", fill_req_valid, req_ready);
        end
        reset    = 1'b0;
        fill_ack = 1'b1;
        model_reset();
        @(negedge clock);
        fill_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (fill_req_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || miss_count !== 16'd0) begin
            failures++;
            $display("FAIL midfill_late_ack fill_valid=%b ready=%b resp_valid=%b misses=%0d expected 0/1/0/0",
                     fill_req_valid, req_ready, resp_valid, miss_count);
        end
        model_access(a, 3, e);
        do_access(a, 3, 1'b0, g);
        checks++;
        if (g !== e || g.hit !== 1'b0) begin
            failures++;
            $display("FAIL midfill_reaccess got=%h exp=%h", g, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        fill_ack  = 1'b0;
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_subblock_miss();
        test_lfu_victim();
        test_lru_tiebreak();
        test_random();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
